sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, parametrised FIFO; successor to the dual-clock 2-deep-address FIFO. Adds registered occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode. Sits between any producer/consumer pair in one clock domain, e.g. a command queue ahead of a bus master.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 2, depth = 2**ADDR_WIDTH words (DEPTH)
- ALMOST_FULL_TH, DEPTH-1, almost_full asserted when count >= this value (1..DEPTH)
- ALMOST_EMPTY_TH, 1, almost_empty asserted when count <= this value (0..DEPTH-1)
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through

- clk  in  1  single clock, rising edge
- Sync_Reset  in  1  synchronous, active-high reset
- Wr_enable  in  1  write request
- data_in  in  DATA_WIDTH  write data
- Read_enable  in  1  read request (FWFT: pop head)
- data_out  out  DATA_WIDTH  read data
- data_valid  out  1  data_out holds a valid word
- full_flg_out  out  1  count == DEPTH
- empty_flg_out  out  1  count == 0
- almost_full  out  1  count >= ALMOST_FULL_TH
- almost_empty  out  1  count <= ALMOST_EMPTY_TH
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Reset is synchronous and active-high: sampled on rising clk; Sync_Reset high at an edge overrides all other inputs.
- Reset values: data_out 0, data_valid 0, full 0, empty 1, almost_full 0, almost_empty 1, count 0, overflow 0, underflow 0; rd/wr pointers 0. Memory contents not cleared.
- Pointers ADDR_WIDTH+1 bits; low ADDR_WIDTH bits index memory, wrap naturally at DEPTH; full = MSBs differ & low bits equal; empty = pointers equal.
- Write accepted iff Wr_enable & !full_flg_out (no bypass: full FIFO rejects writes even with simultaneous read).
- Read accepted iff Read_enable & !empty_flg_out (no bypass: empty FIFO rejects reads even with simultaneous write).
- Both accepted same edge: count unchanged, both pointers advance.
- Rejected write: memory/pointers unchanged, overflow set. Rejected read: pointers and data_out unchanged, underflow set. Sticky bits clear only on reset.
- Standard mode (FWFT=0): accepted read loads data_out from mem[rd_ptr]; data_valid high for the following cycle only; data_out otherwise holds last value.
- FWFT mode: data_out = mem[rd_ptr] whenever !empty, data_valid = !empty_flg_out; Read_enable pops the shown word.
- Reset mid-operation: all queued data discarded; words written the reset cycle are lost.

## Timing
- All flags and count are registered state (or decoded from registered pointers/count only); they reflect accepts at edge N from after edge N.
- Write-to-read latency: word written at edge N is readable (accepted read) at edge N+1; FWFT shows it on data_out after edge N.
- Standard read latency: 1 cycle (Read_enable at edge N -> data_out/data_valid after edge N).
- Full throughput: one write and one read per cycle sustained when neither full nor empty.
- No combinational path from Read_enable/Wr_enable to any output.

## Structure
- Package sync_fifo_pkg: default parameter constants, function for pointer width (ADDR_WIDTH+1), threshold legality checks (elaboration-time assertions).
- One sub-module: fifo_mem_dp — DEPTH x DATA_WIDTH simple dual-port RAM, synchronous write, asynchronous read (read register lives in sync_fifo for FWFT=0).
- Top holds pointers, count, flag decode, sticky errors, output register.

## Test plan (DATA_WIDTH=8, ADDR_WIDTH=2, ALMOST_FULL_TH=3, ALMOST_EMPTY_TH=1)
- Read after reset with FIFO empty -> underflow=1, data_valid=0, data_out=0, count=0.
- Write 5,8,10,12 -> count 1..4, almost_full at count 3, full at 4; fifth write 99 -> overflow=1, count stays 4; four reads return 5,8,10,12 each with one-cycle data_valid.
- Fill to 3, then 6 cycles of simultaneous write(k)/read -> count stays 3, pointers wrap, outputs in exact write order.
- Full FIFO, simultaneous write+read -> read accepted, write rejected, overflow=1, count=3.
- FWFT=1: write 0x5A to empty -> data_out=0x5A, data_valid=1 next cycle without Read_enable; pop -> empty=1, data_valid=0.
- Sync_Reset high mid-stream with count=2 and overflow=1 -> next cycle count=0, empty=1, overflow=0, data_valid=0; subsequent write/read returns only the new word.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and elaboration-time parameter helpers for sync_fifo.
// No logic, so no latency or backpressure.
package sync_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 2;
    localparam int DEF_ALMOST_EMPTY_TH = 1;

    // One extra pointer bit tells a full FIFO from an empty one.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic bit af_th_ok(input int th, input int addr_width);
        return (th >= 1) && (th <= (1 << addr_width));
    endfunction

    function automatic bit ae_th_ok(input int th, input int addr_width);
        return (th >= 0) && (th <= (1 << addr_width) - 1);
    endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Simple dual-port RAM, synchronous write and asynchronous read.
// Write lands on the edge; read is combinational. No backpressure.
module fifo_mem_dp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with count, almost flags, sticky errors and optional FWFT; 1-cycle read latency.
// Writes to a full FIFO and reads from an empty one are dropped and flagged in the sticky error bits.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int ALMOST_FULL_TH  = (1 << ADDR_WIDTH) - 1,
    parameter int ALMOST_EMPTY_TH = DEF_ALMOST_EMPTY_TH,
    parameter bit FWFT            = 1'b0
) (
    input  logic                  clk,
    input  logic                  Sync_Reset,
    input  logic                  Wr_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  Read_enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  full_flg_out,
    output logic                  empty_flg_out,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = ptr_width(ADDR_WIDTH);
    localparam logic [PW-1:0] AF_TH = PW'(ALMOST_FULL_TH);
    localparam logic [PW-1:0] AE_TH = PW'(ALMOST_EMPTY_TH);

    if (!af_th_ok(ALMOST_FULL_TH, ADDR_WIDTH)) begin : g_af_th_bad
        $error("sync_fifo: ALMOST_FULL_TH out of range 1..DEPTH");
    end
    if (!ae_th_ok(ALMOST_EMPTY_TH, ADDR_WIDTH)) begin : g_ae_th_bad
        $error("sync_fifo: ALMOST_EMPTY_TH out of range 0..DEPTH-1");
    end

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] rd_data;

    assign full_flg_out  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                           (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign empty_flg_out = (wr_ptr == rd_ptr);
    assign almost_full   = (count >= AF_TH);
    assign almost_empty  = (count <= AE_TH);

    assign wr_acc = Wr_enable   && !full_flg_out  && !Sync_Reset;
    assign rd_acc = Read_enable && !empty_flg_out && !Sync_Reset;

    always_ff @(posedge clk) begin
        if (Sync_Reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + PW'(1);
                2'b01:   count <= count - PW'(1);
                default: count <= count;
            endcase
            if (Wr_enable && full_flg_out) begin
                overflow <= 1'b1;
            end
            if (Read_enable && empty_flg_out) begin
                underflow <= 1'b1;
            end
        end
    end

    fifo_mem_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[ADDR_WIDTH-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr[ADDR_WIDTH-1:0]),
        .rdata (rd_data)
    );

    if (FWFT) begin : g_fwft
        // Head word is shown straight from the RAM; blanked when there is nothing to show.
        assign data_out   = empty_flg_out ? '0 : rd_data;
        assign data_valid = !empty_flg_out;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q;
        logic                  dvld_q;

        always_ff @(posedge clk) begin
            if (Sync_Reset) begin
                dout_q <= '0;
                dvld_q <= 1'b0;
            end else begin
                dvld_q <= rd_acc;
                if (rd_acc) begin
                    dout_q <= rd_data;
                end
            end
        end

        assign data_out   = dout_q;
        assign data_valid = dvld_q;
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a standard-read instance and an FWFT instance share clock and reset.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       we = 1'b0, re = 1'b0;
    logic [7:0] din = '0, dout;
    logic       dv, full, empty, af, ae, ovf, udf;
    logic [2:0] cnt;

    logic       fw_we = 1'b0, fw_re = 1'b0;
    logic [7:0] fw_din = '0, fw_dout;
    logic       fw_dv, fw_full, fw_empty, fw_af, fw_ae, fw_ovf, fw_udf;
    logic [2:0] fw_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .ALMOST_FULL_TH(3),
                .ALMOST_EMPTY_TH(1), .FWFT(1'b0)) dut (
        .clk(clk), .Sync_Reset(rst), .Wr_enable(we), .data_in(din),
        .Read_enable(re), .data_out(dout), .data_valid(dv),
        .full_flg_out(full), .empty_flg_out(empty), .almost_full(af),
        .almost_empty(ae), .count(cnt), .overflow(ovf), .underflow(udf)
    );

    sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .ALMOST_FULL_TH(3),
                .ALMOST_EMPTY_TH(1), .FWFT(1'b1)) dut_fw (
        .clk(clk), .Sync_Reset(rst), .Wr_enable(fw_we), .data_in(fw_din),
        .Read_enable(fw_re), .data_out(fw_dout), .data_valid(fw_dv),
        .full_flg_out(fw_full), .empty_flg_out(fw_empty), .almost_full(fw_af),
        .almost_empty(fw_ae), .count(fw_cnt), .overflow(fw_ovf), .underflow(fw_udf)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        we = 1'b0; re = 1'b0; fw_we = 1'b0; fw_re = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({cnt, empty, full, af, ae, dv, ovf, udf} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_flags cnt=%0d empty=%b full=%b af=%b ae=%b dv=%b ovf=%b udf=%b", cnt, empty, full, af, ae, dv, ovf, udf);
        end
        checks++;
        if (dout !== 8'h00) begin
            errors++; $display("FAIL reset_dout got %h want 00", dout);
        end
        checks++;
        if ({fw_cnt, fw_empty, fw_dv, fw_dout} !== {3'd0, 1'b1, 1'b0, 8'h00}) begin
            errors++; $display("FAIL reset_fwft cnt=%0d empty=%b dv=%b dout=%h", fw_cnt, fw_empty, fw_dv, fw_dout);
        end
    endtask

    task automatic test_underflow();
        re = 1'b1;
        step();
        re = 1'b0;
        checks++;
        if ({udf, dv, dout, cnt} !== {1'b1, 1'b0, 8'h00, 3'd0}) begin
            errors++; $display("FAIL underflow got udf=%b dv=%b dout=%h cnt=%0d want 1 0 00 0", udf, dv, dout, cnt);
        end
        step();
        checks++;
        if (udf !== 1'b1) begin
            errors++; $display("FAIL underflow_sticky got %b want 1", udf);
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] vals [4] = '{8'd5, 8'd8, 8'd10, 8'd12};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; din = vals[i];
            step();
            checks++;
            if ({cnt, af, full, ae} !== {3'(i + 1), (i + 1 >= 3), (i + 1 == 4), (i + 1 <= 1)}) begin
                errors++; $display("FAIL fill_%0d got cnt=%0d af=%b full=%b ae=%b", i, cnt, af, full, ae);
            end
        end
        din = 8'd99;
        step();
        we = 1'b0;
        checks++;
        if ({ovf, cnt, full} !== {1'b1, 3'd4, 1'b1}) begin
            errors++; $display("FAIL overflow got ovf=%b cnt=%0d full=%b want 1 4 1", ovf, cnt, full);
        end
        for (int i = 0; i < 4; i++) begin
            re = 1'b1;
            step();
            checks++;
            if ({dv, dout, cnt} !== {1'b1, vals[i], 3'(3 - i)}) begin
                errors++; $display("FAIL drain_%0d got dv=%b dout=%0d cnt=%0d want 1 %0d %0d", i, dv, dout, cnt, vals[i], 3 - i);
            end
        end
        re = 1'b0;
        step();
        checks++;
        if ({dv, dout, empty, ae, udf} !== {1'b0, 8'd12, 1'b1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL drain_end got dv=%b dout=%0d empty=%b ae=%b udf=%b want 0 12 1 1 0", dv, dout, empty, ae, udf);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [6] = '{8'd1, 8'd2, 8'd3, 8'd10, 8'd11, 8'd12};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            we = 1'b1; din = 8'(i + 1);
            step();
        end
        for (int k = 0; k < 6; k++) begin
            we = 1'b1; re = 1'b1; din = 8'(10 + k);
            step();
            checks++;
            if ({dv, dout, cnt} !== {1'b1, exp[k], 3'd3}) begin
                errors++; $display("FAIL stream_%0d got dv=%b dout=%0d cnt=%0d want 1 %0d 3", k, dv, dout, cnt, exp[k]);
            end
        end
        // FIFO now holds 13,14,15; top it up to full.
        re = 1'b0; din = 8'd16;
        step();
        checks++;
        if ({full, cnt, ovf} !== {1'b1, 3'd4, 1'b0}) begin
            errors++; $display("FAIL refill got full=%b cnt=%0d ovf=%b want 1 4 0", full, cnt, ovf);
        end
        we = 1'b1; re = 1'b1; din = 8'd77;
        step();
        we = 1'b0; re = 1'b0;
        checks++;
        if ({dout, dv, ovf, cnt, full} !== {8'd13, 1'b1, 1'b1, 3'd3, 1'b0}) begin
            errors++; $display("FAIL full_rw got dout=%0d dv=%b ovf=%b cnt=%0d full=%b want 13 1 1 3 0", dout, dv, ovf, cnt, full);
        end
    endtask

    task automatic test_reset_mid();
        re = 1'b1;
        step();
        re = 1'b0;
        checks++;
        if ({dout, cnt, ovf} !== {8'd14, 3'd2, 1'b1}) begin
            errors++; $display("FAIL pre_reset got dout=%0d cnt=%0d ovf=%b want 14 2 1", dout, cnt, ovf);
        end
        rst = 1'b1; we = 1'b1; din = 8'd55;
        step();
        rst = 1'b0; we = 1'b0;
        checks++;
        if ({cnt, empty, ovf, dv, dout} !== {3'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            errors++; $display("FAIL mid_reset got cnt=%0d empty=%b ovf=%b dv=%b dout=%h", cnt, empty, ovf, dv, dout);
        end
        we = 1'b1; din = 8'h33;
        step();
        we = 1'b0; re = 1'b1;
        step();
        checks++;
        if ({dv, dout, empty} !== {1'b1, 8'h33, 1'b1}) begin
            errors++; $display("FAIL post_reset_rd got dv=%b dout=%h empty=%b want 1 33 1", dv, dout, empty);
        end
        step();
        re = 1'b0;
        checks++;
        if ({dv, dout, udf, cnt} !== {1'b0, 8'h33, 1'b1, 3'd0}) begin
            errors++; $display("FAIL post_reset_empty got dv=%b dout=%h udf=%b cnt=%0d want 0 33 1 0", dv, dout, udf, cnt);
        end
    endtask

    task automatic test_fwft();
        do_reset();
        fw_we = 1'b1; fw_din = 8'h5A;
        step();
        fw_we = 1'b0;
        checks++;
        if ({fw_dout, fw_dv, fw_empty, fw_cnt} !== {8'h5A, 1'b1, 1'b0, 3'd1}) begin
            errors++; $display("FAIL fwft_show got dout=%h dv=%b empty=%b cnt=%0d want 5a 1 0 1", fw_dout, fw_dv, fw_empty, fw_cnt);
        end
        step();
        checks++;
        if ({fw_dout, fw_dv} !== {8'h5A, 1'b1}) begin
            errors++; $display("FAIL fwft_hold got dout=%h dv=%b want 5a 1", fw_dout, fw_dv);
        end
        fw_re = 1'b1;
        step();
        fw_re = 1'b0;
        checks++;
        if ({fw_empty, fw_dv, fw_cnt, fw_udf} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
            errors++; $display("FAIL fwft_pop got empty=%b dv=%b cnt=%0d udf=%b want 1 0 0 0", fw_empty, fw_dv, fw_cnt, fw_udf);
        end
        fw_we = 1'b1; fw_din = 8'hA1;
        step();
        fw_din = 8'hA2;
        step();
        fw_we = 1'b0; fw_re = 1'b1;
        step();
        fw_re = 1'b0;
        checks++;
        if ({fw_dout, fw_dv, fw_cnt} !== {8'hA2, 1'b1, 3'd1}) begin
            errors++; $display("FAIL fwft_second got dout=%h dv=%b cnt=%0d want a2 1 1", fw_dout, fw_dv, fw_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_underflow();
        test_fill_drain();
        test_back_to_back();
        test_reset_mid();
        test_fwft();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
